// File: rtl/stepper_array_if.sv
// Command/status bundle for the multi-channel stepper driver.
// The controller drives moves and aborts; the driver returns coil, busy, done and remaining steps.
interface stepper_array_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16,
   parameter int DIV_W  = 20
);
   logic [NUM_CH-1:0]       cmd_valid_i;
   logic [NUM_CH-1:0]       cmd_ready_o;
   logic [NUM_CH*CNT_W-1:0] cmd_steps_i;
   logic [NUM_CH*DIV_W-1:0] cmd_period_i;
   logic [NUM_CH-1:0]       cmd_dir_i;
   logic [NUM_CH-1:0]       cmd_half_i;
   logic [NUM_CH-1:0]       abort_i;
   logic [NUM_CH*4-1:0]     coil_o;
   logic [NUM_CH-1:0]       busy_o;
   logic [NUM_CH-1:0]       done_o;
   logic [NUM_CH*CNT_W-1:0] remain_o;

   modport master (
      output cmd_valid_i, cmd_steps_i, cmd_period_i, cmd_dir_i, cmd_half_i, abort_i,
      input  cmd_ready_o, coil_o, busy_o, done_o, remain_o
   );

   modport slave (
      input  cmd_valid_i, cmd_steps_i, cmd_period_i, cmd_dir_i, cmd_half_i, abort_i,
      output cmd_ready_o, coil_o, busy_o, done_o, remain_o
   );
endinterface

// File: rtl/stepper_array.sv
// Independent 4-phase stepper channels: each takes a move command, then steps its
// phase index every P clocks until the step count is used up or the move is aborted.
module stepper_array #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16,
   parameter int DIV_W  = 20,
   parameter bit HOLD   = 1'b1
) (
   input logic            clk,
   input logic            rst,
   stepper_array_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] PATTERN [8] = '{
      4'b1000, 4'b1100, 4'b0100, 4'b0110,
      4'b0010, 4'b0011, 4'b0001, 4'b1001
   };

   logic [NUM_CH-1:0]       ready_all;
   logic [NUM_CH-1:0]       busy_all;
   logic [NUM_CH-1:0]       done_all;
   logic [NUM_CH*CNT_W-1:0] remain_all;
   logic [NUM_CH*4-1:0]     coil_all;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         state_t           state_reg;
         logic [2:0]       idx_reg;
         logic [CNT_W-1:0] remain_reg;
         logic [DIV_W-1:0] period_reg;
         logic [DIV_W-1:0] div_reg;
         logic             dir_reg;
         logic             half_reg;
         logic             energised_reg;
         logic             done_reg;

         logic [CNT_W-1:0] cmd_steps;
         logic [DIV_W-1:0] cmd_period;
         logic [DIV_W-1:0] period_eff;
         logic             step_fire;
         logic [2:0]       idx_step;

         assign cmd_steps  = bus.cmd_steps_i[gi*CNT_W +: CNT_W];
         assign cmd_period = bus.cmd_period_i[gi*DIV_W +: DIV_W];
         // A zero period is latched as 1 so the divider compare never underflows.
         assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
         assign step_fire  = (div_reg == period_reg - DIV_W'(1));

         always_comb begin
            idx_step = idx_reg;
            case ({half_reg, dir_reg})
               2'b10:   idx_step = idx_reg + 3'd1;
               2'b11:   idx_step = idx_reg - 3'd1;
               2'b00:   idx_step = idx_reg + 3'd2;
               default: idx_step = idx_reg - 3'd2;
            endcase
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg     <= IDLE;
               idx_reg       <= 3'd0;
               remain_reg    <= '0;
               period_reg    <= DIV_W'(1);
               div_reg       <= '0;
               dir_reg       <= 1'b0;
               half_reg      <= 1'b0;
               energised_reg <= 1'b0;
               done_reg      <= 1'b0;
            end else begin
               done_reg <= 1'b0;
               case (state_reg)
                  IDLE: begin
                     if (bus.cmd_valid_i[gi]) begin
                        if (cmd_steps != '0) begin
                           state_reg     <= RUN;
                           remain_reg    <= cmd_steps;
                           period_reg    <= period_eff;
                           dir_reg       <= bus.cmd_dir_i[gi];
                           half_reg      <= bus.cmd_half_i[gi];
                           div_reg       <= '0;
                           energised_reg <= 1'b1;
                        end else begin
                           done_reg <= 1'b1;
                        end
                     end
                  end
                  RUN: begin
                     // Abort wins over a step that would fire on the same edge.
                     if (bus.abort_i[gi]) begin
                        state_reg  <= IDLE;
                        remain_reg <= '0;
                        div_reg    <= '0;
                     end else if (step_fire) begin
                        idx_reg    <= idx_step;
                        remain_reg <= remain_reg - CNT_W'(1);
                        div_reg    <= '0;
                        if (remain_reg == CNT_W'(1)) begin
                           state_reg <= IDLE;
                           done_reg  <= 1'b1;
                        end
                     end else begin
                        div_reg <= div_reg + DIV_W'(1);
                     end
                  end
                  default: state_reg <= IDLE;
               endcase
            end
         end

         assign ready_all[gi]               = (state_reg == IDLE);
         assign busy_all[gi]                = (state_reg == RUN);
         assign done_all[gi]                = done_reg;
         assign remain_all[gi*CNT_W +: CNT_W] = remain_reg;
         assign coil_all[gi*4 +: 4] =
            ((state_reg == RUN) || (HOLD && energised_reg)) ? PATTERN[idx_reg] : 4'b0000;
      end
   endgenerate

   assign bus.cmd_ready_o = ready_all;
   assign bus.busy_o      = busy_all;
   assign bus.done_o      = done_all;
   assign bus.remain_o    = remain_all;
   assign bus.coil_o      = coil_all;
endmodule

// File: tb/tb_stepper_array.sv
// Drives one stimulus stream into a HOLD=1 and a HOLD=0 driver and checks both against
// a closed-form model: steps taken = min((edge - accept_edge) / P, N).
module tb_stepper_array;
   localparam int NC = 2;
   localparam int CW = 16;
   localparam int DW = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NC-1:0]    valid = '0;
   logic [NC-1:0]    dir   = '0;
   logic [NC-1:0]    half  = '0;
   logic [NC-1:0]    abort = '0;
   logic [NC*CW-1:0] steps = '0;
   logic [NC*DW-1:0] period = '0;

   stepper_array_if #(.NUM_CH(NC), .CNT_W(CW), .DIV_W(DW)) bus_h ();
   stepper_array_if #(.NUM_CH(NC), .CNT_W(CW), .DIV_W(DW)) bus_z ();

   assign bus_h.cmd_valid_i  = valid;
   assign bus_h.cmd_steps_i  = steps;
   assign bus_h.cmd_period_i = period;
   assign bus_h.cmd_dir_i    = dir;
   assign bus_h.cmd_half_i   = half;
   assign bus_h.abort_i      = abort;
   assign bus_z.cmd_valid_i  = valid;
   assign bus_z.cmd_steps_i  = steps;
   assign bus_z.cmd_period_i = period;
   assign bus_z.cmd_dir_i    = dir;
   assign bus_z.cmd_half_i   = half;
   assign bus_z.abort_i      = abort;

   stepper_array #(.NUM_CH(NC), .CNT_W(CW), .DIV_W(DW), .HOLD(1'b1)) dut_h (
      .clk(clk), .rst(rst), .bus(bus_h));
   stepper_array #(.NUM_CH(NC), .CNT_W(CW), .DIV_W(DW), .HOLD(1'b0)) dut_z (
      .clk(clk), .rst(rst), .bus(bus_z));

   logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                           4'b0010, 4'b0011, 4'b0001, 4'b1001};
   logic [3:0] plan1 [4] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010};
   logic [3:0] plan2 [3] = '{4'b0100, 4'b1000, 4'b0001};

   int n_checks = 0;
   int n_errors = 0;
   int edge_cnt = 0;

   // Model: while running, m_idx holds the start index; when idle, the current index.
   bit m_run [NC];
   bit m_en  [NC];
   int m_t [NC];
   int m_p [NC];
   int m_n [NC];
   int m_delta [NC];
   int m_idx [NC];
   int m_done_edge [NC];

   function automatic int wrap8(input int x);
      return ((x % 8) + 8) % 8;
   endfunction

   task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s ch%0d edge %0d: observed %0h expected %0h", tag, c, edge_cnt, got, exp);
      end
   endtask

   task automatic model_edge(input int c, input logic r, input logic v, input logic [CW-1:0] s,
                             input logic [DW-1:0] p, input logic d, input logic h, input logic ab);
      int k;
      if (r) begin
         m_run[c] = 0; m_idx[c] = 0; m_en[c] = 0; m_done_edge[c] = -1;
         return;
      end
      if (m_run[c]) begin
         if (ab) begin
            k = (edge_cnt - 1 - m_t[c]) / m_p[c];
            m_idx[c] = wrap8(m_idx[c] + k * m_delta[c]);
            m_run[c] = 0;
         end else if (edge_cnt == m_t[c] + m_n[c] * m_p[c]) begin
            m_idx[c] = wrap8(m_idx[c] + m_n[c] * m_delta[c]);
            m_run[c] = 0;
            m_done_edge[c] = edge_cnt;
         end
      end else if (v) begin
         if (s != '0) begin
            m_run[c]   = 1;
            m_en[c]    = 1;
            m_t[c]     = edge_cnt;
            m_n[c]     = int'(s);
            m_p[c]     = (p == '0) ? 1 : int'(p);
            m_delta[c] = (h ? 1 : 2) * (d ? -1 : 1);
         end else begin
            m_done_edge[c] = edge_cnt;
         end
      end
   endtask

   task automatic check_dut(input string nm, input bit hold, input logic [NC*4-1:0] coil,
                            input logic [NC-1:0] busy, input logic [NC-1:0] done,
                            input logic [NC-1:0] ready, input logic [NC*CW-1:0] remain);
      int k;
      logic [3:0] e_coil;
      logic e_busy;
      int e_rem;
      for (int c = 0; c < NC; c++) begin
         if (m_run[c]) begin
            k = (edge_cnt - m_t[c]) / m_p[c];
            e_busy = 1'b1;
            e_rem = m_n[c] - k;
            e_coil = pat[wrap8(m_idx[c] + k * m_delta[c])];
         end else begin
            e_busy = 1'b0;
            e_rem = 0;
            e_coil = (hold && m_en[c]) ? pat[m_idx[c]] : 4'b0000;
         end
         chk({nm, "_coil"},   c, 32'(coil[c*4 +: 4]),     32'(e_coil));
         chk({nm, "_busy"},   c, 32'(busy[c]),            32'(e_busy));
         chk({nm, "_ready"},  c, 32'(ready[c]),           32'(!e_busy));
         chk({nm, "_done"},   c, 32'(done[c]),            32'(m_done_edge[c] == edge_cnt));
         chk({nm, "_remain"}, c, 32'(remain[c*CW +: CW]), 32'(e_rem));
      end
   endtask

   task automatic tick();
      logic [NC-1:0] v, d, h, ab;
      logic r;
      logic [NC*CW-1:0] s;
      logic [NC*DW-1:0] p;
      v = valid; d = dir; h = half; ab = abort; r = rst; s = steps; p = period;
      @(posedge clk);
      edge_cnt++;
      for (int c = 0; c < NC; c++)
         model_edge(c, r, v[c], s[c*CW +: CW], p[c*DW +: DW], d[c], h[c], ab[c]);
      #1;
      check_dut("hold", 1'b1, bus_h.coil_o, bus_h.busy_o, bus_h.done_o, bus_h.cmd_ready_o, bus_h.remain_o);
      check_dut("nohold", 1'b0, bus_z.coil_o, bus_z.busy_o, bus_z.done_o, bus_z.cmd_ready_o, bus_z.remain_o);
   endtask

   task automatic set_cmd(input int c, input int n, input int p, input bit d, input bit h);
      valid[c] = 1'b1;
      steps[c*CW +: CW] = CW'(n);
      period[c*DW +: DW] = DW'(p);
      dir[c] = d;
      half[c] = h;
   endtask

   initial begin
      for (int c = 0; c < NC; c++) m_done_edge[c] = -1;

      // Reset state
      rst = 1'b1;
      tick(); tick();
      chk("reset_coil", 0, 32'(bus_h.coil_o), 32'd0);
      rst = 1'b0;
      tick();

      // Half-step forward, 4 steps at period 3
      set_cmd(0, 4, 3, 1'b0, 1'b1);
      tick();
      valid = '0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i % 3 == 0) chk("plan1_coil", 0, 32'(bus_h.coil_o[3:0]), 32'(plan1[i/3 - 1]));
      end
      chk("plan1_done", 0, 32'(bus_h.done_o[0]), 32'd1);
      tick();

      // Full-step reverse from index 4, period 1
      set_cmd(0, 3, 1, 1'b1, 1'b0);
      tick();
      valid = '0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("plan2_coil", 0, 32'(bus_h.coil_o[3:0]), 32'(plan2[i - 1]));
      end
      chk("plan2_done", 0, 32'(bus_h.done_o[0]), 32'd1);
      tick();

      // Zero-step command
      set_cmd(0, 0, 2, 1'b0, 1'b1);
      tick();
      valid = '0;
      chk("zero_done", 0, 32'(bus_h.done_o[0]), 32'd1);
      chk("zero_ready", 0, 32'(bus_h.cmd_ready_o[0]), 32'd1);
      tick();
      chk("zero_done_once", 0, 32'(bus_h.done_o[0]), 32'd0);

      // Abort exactly when the 2nd step would fire
      set_cmd(0, 5, 4, 1'b0, 1'b1);
      tick();
      valid = '0;
      for (int i = 1; i <= 7; i++) tick();
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      chk("abort_coil", 0, 32'(bus_h.coil_o[3:0]), 32'(4'b1001));
      chk("abort_busy", 0, 32'(bus_h.busy_o[0]), 32'd0);
      chk("abort_remain", 0, 32'(bus_h.remain_o[CW-1:0]), 32'd0);
      tick(); tick();

      // Two channels in parallel
      set_cmd(0, 3, 2, 1'b0, 1'b1);
      set_cmd(1, 2, 5, 1'b1, 1'b0);
      tick();
      valid = '0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 6) begin
            chk("par_done0", 0, 32'(bus_h.done_o[0]), 32'd1);
            chk("par_z_coil0", 0, 32'(bus_z.coil_o[3:0]), 32'd0);
         end
         if (i == 10) begin
            chk("par_done1", 1, 32'(bus_h.done_o[1]), 32'd1);
            chk("par_z_coil_all", 1, 32'(bus_z.coil_o), 32'd0);
         end
      end
      tick();

      // Randomized commands, aborts and mid-move input churn
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < NC; c++) begin
            valid[c] = ($urandom_range(0, 3) == 0);
            steps[c*CW +: CW] = CW'($urandom_range(0, 5));
            period[c*DW +: DW] = DW'($urandom_range(0, 3));
            dir[c] = 1'($urandom_range(0, 1));
            half[c] = 1'($urandom_range(0, 1));
            abort[c] = ($urandom_range(0, 15) == 0);
         end
         tick();
      end
      valid = '0;
      abort = '0;
      for (int i = 0; i < 30; i++) tick();

      // Reset in the middle of a move
      set_cmd(0, 10, 2, 1'b0, 1'b1);
      set_cmd(1, 10, 2, 1'b1, 1'b0);
      tick();
      valid = '0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_coil", 0, 32'(bus_h.coil_o), 32'd0);
      chk("rst_busy", 0, 32'(bus_h.busy_o), 32'd0);
      tick();
      set_cmd(0, 1, 1, 1'b0, 1'b1);
      tick();
      valid = '0;
      tick();
      chk("rst_restart_coil", 0, 32'(bus_h.coil_o[3:0]), 32'(4'b1100));
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
